// File: rtl/svm_dot_accum.sv
// svm_dot_accum: saturating dot-product accumulator at the consumer end of
// the multiplier product stream. It runs in lockstep with the multiplier
// because both blocks share the same start and svm_enable nets.
//
// Ports:
//   clk, rst_n  - rising-edge clock, synchronous active-low reset
//   svm_enable  - global enable; 0 freezes every register (stall)
//   start       - level; held high for the whole operation
//   busy_four   - multiplier busy; 0 means data_four is valid every cycle
//   data_four   - signed product from the multiplier
//   vec_len     - number of products to sum, captured when start is seen
//   acc_out     - signed saturated sum, held until the next operation
//   acc_valid   - one-enabled-cycle pulse while acc_out is final
//   acc_busy    - high from operation start through the acc_valid cycle
//   overflow    - sticky saturation flag, cleared at operation start
module svm_dot_accum #(
   parameter int DATA_WIDTH = 32,
   parameter int ACC_WIDTH  = 40,
   parameter int LEN_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  svm_enable,
   input  logic                  start,
   input  logic                  busy_four,
   input  logic [DATA_WIDTH-1:0] data_four,
   input  logic [LEN_WIDTH-1:0]  vec_len,
   output logic [ACC_WIDTH-1:0]  acc_out,
   output logic                  acc_valid,
   output logic                  acc_busy,
   output logic                  overflow
);

   typedef enum logic [2:0] {IDLE, FILL, ACCUM, DONE, WAIT_LOW} state_t;

   localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
   localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

   state_t                 state_q;
   logic [ACC_WIDTH-1:0]   acc_q, acc_d;
   logic [ACC_WIDTH-1:0]   acc_out_q;
   logic [LEN_WIDTH-1:0]   cnt_q, cnt_d;
   logic [LEN_WIDTH-1:0]   len_q;
   logic                   valid_q, busy_q, ovf_q, ovf_d;

   logic [ACC_WIDTH:0]     data_ext, sum_w;
   logic                   sat_pos, sat_neg;

   // One guard bit above the accumulator: the top two bits of the sum
   // disagree exactly when the true result left the ACC_WIDTH range.
   always_comb begin
      data_ext = {{(ACC_WIDTH+1-DATA_WIDTH){data_four[DATA_WIDTH-1]}}, data_four};
      sum_w    = {acc_q[ACC_WIDTH-1], acc_q} + data_ext;
      sat_pos  = ~sum_w[ACC_WIDTH] &  sum_w[ACC_WIDTH-1];
      sat_neg  =  sum_w[ACC_WIDTH] & ~sum_w[ACC_WIDTH-1];
      acc_d    = sum_w[ACC_WIDTH-1:0];
      if (sat_pos) acc_d = ACC_MAX;
      if (sat_neg) acc_d = ACC_MIN;
      ovf_d    = ovf_q | sat_pos | sat_neg;
      cnt_d    = cnt_q + LEN_WIDTH'(1);
   end

   // The result is published on entry to DONE, so the DONE cycle itself is
   // the acc_valid cycle and acc_busy naturally covers it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         acc_q     <= '0;
         acc_out_q <= '0;
         cnt_q     <= '0;
         len_q     <= '0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         ovf_q     <= 1'b0;
      end else if (svm_enable) begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  len_q  <= vec_len;
                  acc_q  <= '0;
                  cnt_q  <= '0;
                  ovf_q  <= 1'b0;
                  busy_q <= 1'b1;
                  if (vec_len == '0) begin
                     state_q   <= DONE;
                     valid_q   <= 1'b1;
                     acc_out_q <= '0;
                  end else begin
                     state_q <= FILL;
                  end
               end
            end
            FILL: begin
               if (!start) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else if (!busy_four) begin
                  acc_q <= acc_d;
                  ovf_q <= ovf_d;
                  cnt_q <= LEN_WIDTH'(1);
                  if (len_q == LEN_WIDTH'(1)) begin
                     state_q   <= DONE;
                     valid_q   <= 1'b1;
                     acc_out_q <= acc_d;
                  end else begin
                     state_q <= ACCUM;
                  end
               end
            end
            ACCUM: begin
               // The multiplier streams back-to-back once it has filled, so
               // busy_four is no longer consulted here.
               if (!start) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  acc_q <= acc_d;
                  ovf_q <= ovf_d;
                  cnt_q <= cnt_d;
                  if (cnt_d == len_q) begin
                     state_q   <= DONE;
                     valid_q   <= 1'b1;
                     acc_out_q <= acc_d;
                  end
               end
            end
            DONE: begin
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= start ? WAIT_LOW : IDLE;
            end
            WAIT_LOW: begin
               // Start must fall before another operation can begin.
               if (!start) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign acc_out   = acc_out_q;
   assign acc_valid = valid_q;
   assign acc_busy  = busy_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_svm_dot_accum.sv
// Bench for svm_dot_accum: a 40-bit and a 33-bit accumulator share all
// inputs; a per-cycle compare process checks both against a sum model.
module tb_svm_dot_accum;

   logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0, start = 1'b0, bsy = 1'b1;
   logic [31:0] data = '0;
   logic [7:0]  vlen = '0;
   logic [39:0] out40;
   logic [32:0] out33;
   logic        v40, v33, b40, b33, o40, o33;

   always #5 clk = ~clk;

   svm_dot_accum #(.DATA_WIDTH(32), .ACC_WIDTH(40), .LEN_WIDTH(8)) dut40 (
      .clk(clk), .rst_n(rst_n), .svm_enable(en), .start(start), .busy_four(bsy),
      .data_four(data), .vec_len(vlen), .acc_out(out40), .acc_valid(v40),
      .acc_busy(b40), .overflow(o40));

   svm_dot_accum #(.DATA_WIDTH(32), .ACC_WIDTH(33), .LEN_WIDTH(8)) dut33 (
      .clk(clk), .rst_n(rst_n), .svm_enable(en), .start(start), .busy_four(bsy),
      .data_four(data), .vec_len(vlen), .acc_out(out33), .acc_valid(v33),
      .acc_busy(b33), .overflow(o33));

   int     n_chk = 0, n_fail = 0;
   bit     chk_en = 1'b0;
   // expected outputs for the current cycle
   bit     e_valid = 1'b0, e_busy = 1'b0, e_ovf40 = 1'b0, e_ovf33 = 1'b0;
   longint e_out40 = 0, e_out33 = 0;
   // running model accumulators
   longint m40 = 0, m33 = 0;
   bit     mo40 = 1'b0, mo33 = 1'b0;
   logic signed [31:0] prod[$];

   task automatic chk(input string name, input logic signed [63:0] act,
                      input logic signed [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("valid40", {63'd0, v40}, {63'd0, e_valid});
         chk("valid33", {63'd0, v33}, {63'd0, e_valid});
         chk("busy40",  {63'd0, b40}, {63'd0, e_busy});
         chk("busy33",  {63'd0, b33}, {63'd0, e_busy});
         chk("ovf40",   {63'd0, o40}, {63'd0, e_ovf40});
         chk("ovf33",   {63'd0, o33}, {63'd0, e_ovf33});
         chk("out40",   64'($signed(out40)), e_out40);
         chk("out33",   64'($signed(out33)), e_out33);
      end
   end

   function automatic longint clamp(input longint s, input int w);
      longint mx, mn;
      mx = (longint'(1) <<< (w - 1)) - 1;
      mn = -(longint'(1) <<< (w - 1));
      if (s > mx) return mx;
      if (s < mn) return mn;
      return s;
   endfunction

   task automatic model_add(input logic signed [31:0] d);
      longint s;
      s = m40 + longint'(d); m40 = clamp(s, 40); if (m40 != s) mo40 = 1'b1;
      s = m33 + longint'(d); m33 = clamp(s, 33); if (m33 != s) mo33 = 1'b1;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic stall(input int n);
      en = 1'b0;
      repeat (n) begin data = $urandom; bsy = 1'($urandom_range(0, 1)); tick(); end
      en = 1'b1;
   endtask

   // One operation over prod[0..len-1]. dly: busy cycles after start;
   // abort_at: product index at which start drops (-1 = none); stall_at:
   // product index preceded by a stall, also stalls the valid cycle;
   // hold: keep start high after the result.
   task automatic run_op(input int len, input int dly, input int abort_at,
                         input int stall_at, input int stall_n, input bit hold);
      bit aborted;
      aborted = 1'b0;
      en = 1'b1; start = 1'b1; vlen = 8'(len); bsy = 1'b1; data = $urandom;
      tick();
      m40 = 0; m33 = 0; mo40 = 1'b0; mo33 = 1'b0;
      e_busy = 1'b1; e_valid = 1'b0; e_ovf40 = 1'b0; e_ovf33 = 1'b0;
      vlen = 8'($urandom);  // must be ignored after capture
      if (len == 0) begin
         e_valid = 1'b1; e_out40 = 0; e_out33 = 0;
      end else begin
         repeat (dly) begin bsy = 1'b1; data = $urandom; tick(); end
         for (int i = 0; i < len; i++) begin
            if (i == abort_at) begin
               start = 1'b0; data = $urandom; bsy = 1'b0; tick();
               e_busy = 1'b0;
               aborted = 1'b1;
               break;
            end
            if (i == stall_at) stall(stall_n);
            data = prod[i];
            bsy = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            tick();
            model_add(prod[i]);
            e_ovf40 = mo40; e_ovf33 = mo33;
            if (i == len - 1) begin e_valid = 1'b1; e_out40 = m40; e_out33 = m33; end
         end
      end
      if (!aborted) begin
         if (stall_at >= 0 && stall_n > 0) stall(stall_n);
         start = hold; tick();
         e_valid = 1'b0; e_busy = 1'b0;
         if (hold) begin
            vlen = 8'd3; bsy = 1'b0;
            repeat (3) tick();
            start = 1'b0; tick();
         end
      end
   endtask

   initial begin
      // reset has priority over a disabled, started block
      rst_n = 1'b0; start = 1'b1; en = 1'b0; vlen = 8'd4;
      tick();
      chk_en = 1'b1;
      tick();
      rst_n = 1'b1; start = 1'b0; en = 1'b1;
      repeat (2) tick();

      // start with enable low must not begin an operation
      en = 1'b0; start = 1'b1; tick(); tick();
      start = 1'b0; en = 1'b1; tick();

      // basic dot product
      prod = '{32'sd10, -32'sd3, 32'sd100, -32'sd7};
      run_op(4, 2, -1, -1, 0, 1'b0);
      chk("basic_lit", 64'($signed(out40)), 64'sd100);

      // saturation: fits in 40 bits, clamps in 33 bits
      prod.delete();
      for (int i = 0; i < 255; i++) prod.push_back(32'sh7FFFFFFF);
      run_op(255, 0, -1, -1, 0, 1'b0);
      chk("sat40_lit", 64'($signed(out40)), 64'sd547608329985);
      chk("sat33_lit", 64'($signed(out33)), 64'sd4294967295);
      chk("sat33_ovf_lit", {63'd0, o33}, 64'sd1);
      chk("sat40_ovf_lit", {63'd0, o40}, 64'sd0);

      // stall between 2nd and 3rd product and during the valid cycle
      prod = '{32'sd5, 32'sd6, 32'sd7};
      run_op(3, 1, -1, 2, 2, 1'b0);
      chk("stall_lit", 64'($signed(out40)), 64'sd18);
      chk("ovf_cleared_lit", {63'd0, o33}, 64'sd0);

      // abort after two products, then restart
      prod = '{32'sd9, 32'sd9, 32'sd9, 32'sd9, 32'sd9};
      run_op(5, 1, 2, -1, 0, 1'b0);
      chk("abort_lit", 64'($signed(out40)), 64'sd18);
      prod = '{-32'sd4, -32'sd4};
      run_op(2, 0, -1, -1, 0, 1'b0);
      chk("restart_lit", 64'($signed(out40)), -64'sd8);

      // edge lengths
      run_op(0, 0, -1, -1, 0, 1'b0);
      chk("len0_lit", 64'($signed(out40)), 64'sd0);
      prod = '{-32'sd1};
      run_op(1, 3, -1, -1, 0, 1'b1);
      chk("len1_lit", 64'($signed(out40)), -64'sd1);

      // randomized operations
      for (int k = 0; k < 40; k++) begin
         int len;
         len = $urandom_range(0, 12);
         prod.delete();
         for (int i = 0; i < len; i++) prod.push_back($urandom);
         run_op(len, $urandom_range(0, 3),
                ($urandom_range(0, 5) == 0 && len > 1) ? $urandom_range(0, len - 1) : -1,
                ($urandom_range(0, 3) == 0 && len > 0) ? $urandom_range(0, len - 1) : -1,
                $urandom_range(1, 3), 1'($urandom_range(0, 1)));
      end

      // reset mid-operation, with enable low, aborts and clears everything
      prod = '{32'sd1, 32'sd2, 32'sd3, 32'sd4};
      en = 1'b1; start = 1'b1; vlen = 8'd4; bsy = 1'b0; tick();
      e_busy = 1'b1; e_ovf40 = 1'b0; e_ovf33 = 1'b0; m40 = 0; m33 = 0;
      data = 32'd1; tick(); data = 32'd2; tick();
      rst_n = 1'b0; en = 1'b0; tick();
      e_busy = 1'b0; e_valid = 1'b0; e_out40 = 0; e_out33 = 0;
      rst_n = 1'b1; en = 1'b1; start = 1'b0; repeat (3) tick();

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
